// File: rtl/trap_ctrl_pkg.sv
// trap_ctrl_pkg: shared constants for the machine-mode trap controller.
//   XLEN            - architectural register width
//   CAUSE_*         - mcause exception/interrupt codes
//   ST_*            - trap FSM state encodings
//   MTVEC_*         - mtvec.MODE field values
//   mtvec_base()    - strip the mode bits from mtvec
package trap_ctrl_pkg;

  localparam int XLEN = 32;

  localparam logic [3:0] CAUSE_IFMIS = 4'd0;
  localparam logic [3:0] CAUSE_ILL   = 4'd2;
  localparam logic [3:0] CAUSE_BREAK = 4'd3;
  localparam logic [3:0] CAUSE_ECALL = 4'd11;
  localparam logic [3:0] CAUSE_MSI   = 4'd3;
  localparam logic [3:0] CAUSE_MTI   = 4'd7;
  localparam logic [3:0] CAUSE_MEI   = 4'd11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SAVE = 2'd1;
  localparam logic [1:0] ST_JUMP = 2'd2;

  localparam logic [1:0] MTVEC_DIRECT   = 2'd0;
  localparam logic [1:0] MTVEC_VECTORED = 2'd1;

  function automatic logic [XLEN-1:0] mtvec_base(input logic [XLEN-1:0] mtvec);
    return {mtvec[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/trap_ctrl_prio.sv
// trap_prio: combinational selection of the winning trap source.
// Inputs : exception flags (ifmis, ill, ebreak, ecall), interrupt levels
//          (int_soft/int_time/int_exte), global enable mie_glb and per-source
//          enables msie/mtie/meie, faulting instruction word and fetch target.
// Outputs: take_int / take_exc (a trap source is active), cause code and
//          the mtval value that goes with it.
// Interrupts beat exceptions; MEI > MSI > MTI, ifmis > ill > ebreak > ecall.
import trap_ctrl_pkg::*;

module trap_prio (
  input  logic            excp_ifmis,
  input  logic            excp_ill,
  input  logic            ebreak,
  input  logic            ecall,
  input  logic            int_soft,
  input  logic            int_time,
  input  logic            int_exte,
  input  logic            mie_glb,
  input  logic            msie,
  input  logic            mtie,
  input  logic            meie,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] br_tgt,
  output logic            take_int,
  output logic            take_exc,
  output logic [3:0]      code,
  output logic [XLEN-1:0] tval
);

  logic mei_p, msi_p, mti_p;

  assign mei_p = mie_glb & int_exte & meie;
  assign msi_p = mie_glb & int_soft & msie;
  assign mti_p = mie_glb & int_time & mtie;

  assign take_int = mei_p | msi_p | mti_p;
  assign take_exc = excp_ifmis | excp_ill | ebreak | ecall;

  always_comb begin
    code = 4'd0;
    tval = '0;
    if (mei_p)           code = CAUSE_MEI;
    else if (msi_p)      code = CAUSE_MSI;
    else if (mti_p)      code = CAUSE_MTI;
    else if (excp_ifmis) begin
      code = CAUSE_IFMIS;
      tval = br_tgt;
    end
    else if (excp_ill) begin
      code = CAUSE_ILL;
      tval = XLEN'(instr);
    end
    else if (ebreak)     code = CAUSE_BREAK;
    else if (ecall)      code = CAUSE_ECALL;
  end

endmodule

// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap entry / mret sequencer.
// Inputs : commit-boundary instruction info, exception flags, interrupt
//          levels and enables, mtvec / mepc CSR values.
// Outputs: registered CSR write strobes (cause/epc/mtval/mstatus) and
//          pipeline controls (stall, flush, redirect + target).
// Build option: define TRAP_VECTORED_EN to route interrupts through
// vectored mtvec mode (base + 4*cause); otherwise every trap goes to base.
//
// state | meaning
// IDLE  | watch the commit boundary for a trap or mret
// SAVE  | CSR write strobes visible, pipeline stalled and flushed
// JUMP  | trap: redirect visible; mret: mstatus restore strobe visible,
//       | redirect follows on the way back to IDLE
import trap_ctrl_pkg::*;

module trap_ctrl (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            instr_valid_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [31:0]     instr_i,
  input  logic            excp_ifmis_i,
  input  logic            excp_ill_i,
  input  logic            ecall_i,
  input  logic            ebreak_i,
  input  logic            mret_i,
  input  logic [XLEN-1:0] br_tgt_i,
  input  logic            int_soft_i,
  input  logic            int_time_i,
  input  logic            int_exte_i,
  input  logic            csr_mstatus_MIE_i,
  input  logic            csr_mie_msie_i,
  input  logic            csr_mie_mtie_i,
  input  logic            csr_mie_meie_i,
  input  logic [XLEN-1:0] csr_mtvec_i,
  input  logic [XLEN-1:0] csr_mepc_i,
  output logic            cause_int_o,
  output logic            cause_en_o,
  output logic [3:0]      cause_code_o,
  output logic            epc_en_o,
  output logic [XLEN-1:0] epc_val_o,
  output logic            mtval_en_o,
  output logic [XLEN-1:0] mtval_val_o,
  output logic            mstatus_trap_o,
  output logic            mstatus_mret_o,
  output logic            stall_o,
  output logic            flush_o,
  output logic            redirect_o,
  output logic [XLEN-1:0] redirect_pc_o
);

  logic [1:0]      state;
  logic            mret_path;
  logic            take_int, take_exc;
  logic [3:0]      sel_code;
  logic [XLEN-1:0] sel_tval;
  logic [XLEN-1:0] trap_tgt;
  logic            trap_req, mret_req;

  trap_prio u_prio (
    .excp_ifmis (excp_ifmis_i),
    .excp_ill   (excp_ill_i),
    .ebreak     (ebreak_i),
    .ecall      (ecall_i),
    .int_soft   (int_soft_i),
    .int_time   (int_time_i),
    .int_exte   (int_exte_i),
    .mie_glb    (csr_mstatus_MIE_i),
    .msie       (csr_mie_msie_i),
    .mtie       (csr_mie_mtie_i),
    .meie       (csr_mie_meie_i),
    .instr      (instr_i),
    .br_tgt     (br_tgt_i),
    .take_int   (take_int),
    .take_exc   (take_exc),
    .code       (sel_code),
    .tval       (sel_tval)
  );

`ifdef TRAP_VECTORED_EN
  assign trap_tgt = (csr_mtvec_i[1:0] == MTVEC_VECTORED && take_int)
                  ? mtvec_base(csr_mtvec_i) + (XLEN'(sel_code) << 2)
                  : mtvec_base(csr_mtvec_i);
`else
  logic unused_mtvec_mode;
  assign unused_mtvec_mode = ^csr_mtvec_i[1:0];
  assign trap_tgt = mtvec_base(csr_mtvec_i);
`endif

  assign trap_req = instr_valid_i & (take_int | take_exc);
  // mret only retires when nothing outranks it on the same instruction
  assign mret_req = instr_valid_i & mret_i & ~take_int & ~take_exc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      mret_path      <= 1'b0;
      cause_int_o    <= 1'b0;
      cause_en_o     <= 1'b0;
      cause_code_o   <= 4'd0;
      epc_en_o       <= 1'b0;
      epc_val_o      <= '0;
      mtval_en_o     <= 1'b0;
      mtval_val_o    <= '0;
      mstatus_trap_o <= 1'b0;
      mstatus_mret_o <= 1'b0;
      stall_o        <= 1'b0;
      flush_o        <= 1'b0;
      redirect_o     <= 1'b0;
      redirect_pc_o  <= '0;
    end else begin
      cause_en_o     <= 1'b0;
      epc_en_o       <= 1'b0;
      mtval_en_o     <= 1'b0;
      mstatus_trap_o <= 1'b0;
      mstatus_mret_o <= 1'b0;
      flush_o        <= 1'b0;
      redirect_o     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (trap_req) begin
            cause_int_o    <= take_int;
            cause_code_o   <= sel_code;
            epc_val_o      <= pc_i;
            mtval_val_o    <= sel_tval;
            redirect_pc_o  <= trap_tgt;
            cause_en_o     <= 1'b1;
            epc_en_o       <= 1'b1;
            mtval_en_o     <= 1'b1;
            mstatus_trap_o <= 1'b1;
            stall_o        <= 1'b1;
            flush_o        <= 1'b1;
            mret_path      <= 1'b0;
            state          <= ST_SAVE;
          end else if (mret_req) begin
            redirect_pc_o  <= csr_mepc_i;
            mstatus_mret_o <= 1'b1;
            mret_path      <= 1'b1;
            state          <= ST_JUMP;
          end
        end
        ST_SAVE: begin
          stall_o    <= 1'b0;
          redirect_o <= 1'b1;
          state      <= ST_JUMP;
        end
        ST_JUMP: begin
          // mret enters JUMP carrying only the mstatus strobe; its redirect
          // is issued as JUMP completes
          redirect_o <= mret_path;
          mret_path  <= 1'b0;
          stall_o    <= 1'b0;
          state      <= ST_IDLE;
        end
        default: begin
          stall_o   <= 1'b0;
          mret_path <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/trap_ctrl.md
TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 SHALL have ports clk (input, 1, system clock) and rst_n (input, 1, asynchronous active-low reset); one clock, async active-low reset.
REQ-002 SHALL have inputs: instr_valid_i 1 (instruction at commit boundary), pc_i XLEN, instr_i 32, excp_ifmis_i 1 (fetch misaligned), excp_ill_i 1, ecall_i 1, ebreak_i 1, mret_i 1, br_tgt_i XLEN (faulting fetch target).
REQ-003 SHALL have inputs int_soft_i, int_time_i, int_exte_i 1 each (level), csr_mstatus_MIE_i, csr_mie_msie_i, csr_mie_mtie_i, csr_mie_meie_i 1 each, csr_mtvec_i XLEN, csr_mepc_i XLEN.
REQ-004 SHALL have outputs to csr: cause_int_o 1, cause_en_o 1, cause_code_o 4, epc_en_o 1, epc_val_o XLEN, mtval_en_o 1, mtval_val_o XLEN, mstatus_trap_o 1 (MPIE<=MIE, MIE<=0), mstatus_mret_o 1 (MIE<=MPIE, MPIE<=1).
REQ-005 SHALL have outputs to pipeline: stall_o 1, flush_o 1, redirect_o 1, redirect_pc_o XLEN.

Function
REQ-006 SHALL implement FSM states IDLE, SAVE, JUMP; all outputs registered.
REQ-007 IDLE: trap taken when instr_valid_i and (pending interrupt or any exception); capture cause/int/epc/tval, assert stall_o, flush_o next cycle, go SAVE.
REQ-008 Pending interrupt = csr_mstatus_MIE_i & ((int_exte_i&meie)|(int_soft_i&msie)|(int_time_i&mtie)); priority MEI(11) > MSI(3) > MTI(7); cause_int=1.
REQ-009 Interrupt SHALL take priority over any exception or mret on the same instruction; instruction is not committed, epc = pc_i.
REQ-010 Exception priority: ifmis(0) > ill(2) > ebreak(3) > ecall(11); cause_int=0, epc = pc_i.
REQ-011 mtval: ifmis -> br_tgt_i; ill -> zero-extended instr_i; all others (incl. interrupts) -> 0.
REQ-012 SAVE: single-cycle pulse of cause_en_o, epc_en_o, mtval_en_o, mstatus_trap_o with captured values; stall_o=1; go JUMP.
REQ-013 JUMP: single-cycle redirect_o=1 with target per REQ-019; stall_o=0; go IDLE.
REQ-014 mret_i in IDLE with no pending interrupt: pulse mstatus_mret_o, go JUMP with redirect_pc_o = csr_mepc_i sampled that cycle; no CSR cause/epc/mtval writes.
REQ-015 Events in SAVE/JUMP SHALL be ignored (pipeline stalled/flushed); re-evaluated only in IDLE.
REQ-016 Trap entry latency: request cycle N -> CSR write pulses N+1 -> redirect N+2.
REQ-017 Interrupt lines that drop after capture SHALL NOT abort an in-progress trap.

Reset
REQ-018 On rst_n low (including mid-SAVE/JUMP): state IDLE, every output 0, captured registers 0; write pulses abort immediately.

Configuration
REQ-019 Macro TRAP_VECTORED_EN: defined -> if csr_mtvec_i[1:0]==1 and trap is interrupt, target = {mtvec[XLEN-1:2],2'b00} + 4*cause_code, else base; undefined -> target always {mtvec[XLEN-1:2],2'b00}.

Structure
REQ-020 Cause codes (0,2,3,11,3,7,11), FSM state encodings, and mtvec mode values SHALL live in the shared define.v alongside XLEN.
REQ-021 One sub-module trap_prio (combinational cause/tval priority select) is natural; FSM stays in trap_ctrl.

Verification
REQ-022 ecall_i at pc 0x100, MIE=0, mtvec 0x800 -> N+1: cause_en, code 11, int 0, epc 0x100, mtval 0; N+2: redirect to 0x800.
REQ-023 excp_ill_i with instr 0xFFFFFFFF at pc 0x40 -> mtval 0xFFFFFFFF, code 2.
REQ-024 int_time_i & int_exte_i both high, all enables 1, pc 0x200 -> code 11, int 1, epc 0x200, mstatus_trap_o pulse; with TRAP_VECTORED_EN and mtvec 0x801 redirect 0x82C, without it 0x800.
REQ-025 mret_i, mepc 0x104, no interrupt -> mstatus_mret_o pulse N, redirect 0x104 N+1, no cause_en.
REQ-026 rst_n low during SAVE -> all outputs 0 same cycle, IDLE after release, no redirect.
REQ-027 int_soft_i with MIE=0 plus ebreak_i -> exception code 3 only, interrupt not taken.
